// File: rtl/rr_mux_sel.sv
// Round-robin arbiter with a registered data mux: one requesting channel owns the output at a time.
// Optional macro RR_MUX_SEL_TIMEOUT_EN adds a hold counter that forces rotation after MAX_HOLD cycles.
module rr_mux_sel #(
    parameter int WIDTH    = 8,
    parameter int CH       = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [CH-1:0]           req,
    input  logic [CH*WIDTH-1:0]     data_in,
    output logic [CH-1:0]           grant,
    output logic [$clog2(CH)-1:0]   sel,
    output logic [WIDTH-1:0]        out,
    output logic                    valid
);

    localparam int SW = $clog2(CH);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    if (WIDTH < 1 || CH < 2 || MAX_HOLD < 1) begin : g_paramCheck
        $error("rr_mux_sel: WIDTH>=1, CH>=2 and MAX_HOLD>=1 are required");
    end

    state_t          r_state;
    logic [SW-1:0]   r_ptr;

    logic [CH-1:0]   w_selMask;
    logic [CH-1:0]   w_others;
    logic            w_idleFound;
    logic [SW-1:0]   w_idleIdx;
    logic            w_rotFound;
    logic [SW-1:0]   w_rotIdx;
    logic [WIDTH-1:0] w_idleData;
    logic [WIDTH-1:0] w_rotData;
    logic [WIDTH-1:0] w_selData;
    logic            w_force;
    logic            w_keep;

    // First set bit of mask at or after start, wrapping; MSB of the result flags a hit.
    function automatic logic [SW:0] firstFrom(input logic [CH-1:0] mask, input logic [SW-1:0] start);
        logic [SW:0]   res;
        logic [SW-1:0] idxS;
        int            idx;
        res = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            idx  = (int'(start) + k) % CH;
            idxS = SW'(idx);
            if (mask[idxS]) begin
                res = {1'b1, idxS};
            end
        end
        return res;
    endfunction

    function automatic logic [SW-1:0] nextIdx(input logic [SW-1:0] i);
        return (i == SW'(CH - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        w_selMask                 = CH'(1) << sel;
        w_others                  = req & ~w_selMask;
        {w_idleFound, w_idleIdx}  = firstFrom(req, r_ptr);
        {w_rotFound, w_rotIdx}    = firstFrom(w_others, nextIdx(sel));
        w_idleData                = data_in[int'(w_idleIdx)*WIDTH +: WIDTH];
        w_rotData                 = data_in[int'(w_rotIdx)*WIDTH +: WIDTH];
        w_selData                 = data_in[int'(sel)*WIDTH +: WIDTH];
        w_keep                    = req[sel] && !w_force;
    end

`ifdef RR_MUX_SEL_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

    logic [HW-1:0] r_hold;
    logic          w_holdLast;

    assign w_holdLast = (r_hold == HoldLast);
    assign w_force    = w_holdLast && (w_others != '0);
`else
    assign w_force = 1'b0;
`endif

    // Ownership changes always reload out from the new channel so there is no bubble on handover.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            grant   <= '0;
            sel     <= '0;
            out     <= '0;
            valid   <= 1'b0;
`ifdef RR_MUX_SEL_TIMEOUT_EN
            r_hold  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idleFound) begin
                        r_state <= GRANT;
                        grant   <= CH'(1) << w_idleIdx;
                        sel     <= w_idleIdx;
                        out     <= w_idleData;
                        valid   <= 1'b1;
                        r_ptr   <= nextIdx(w_idleIdx);
`ifdef RR_MUX_SEL_TIMEOUT_EN
                        r_hold  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (w_keep) begin
                        out <= w_selData;
`ifdef RR_MUX_SEL_TIMEOUT_EN
                        r_hold <= w_holdLast ? '0 : r_hold + 1'b1;
`endif
                    end else if (w_rotFound) begin
                        grant   <= CH'(1) << w_rotIdx;
                        sel     <= w_rotIdx;
                        out     <= w_rotData;
                        r_ptr   <= nextIdx(w_rotIdx);
`ifdef RR_MUX_SEL_TIMEOUT_EN
                        r_hold  <= '0;
`endif
                    end else begin
                        r_state <= IDLE;
                        grant   <= '0;
                        sel     <= '0;
                        valid   <= 1'b0;
                        r_ptr   <= nextIdx(sel);
`ifdef RR_MUX_SEL_TIMEOUT_EN
                        r_hold  <= '0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // grant, sel and valid must describe the same owner on every cycle.
    a_onehot : assert property (@(posedge clk) disable iff (!rstN) $onehot0(grant));
    a_valid  : assert property (@(posedge clk) disable iff (!rstN) valid == (grant != '0));
    a_sel    : assert property (@(posedge clk) disable iff (!rstN) valid |-> grant == (CH'(1) << sel));
`endif

endmodule

// File: tb/tb_rr_mux_sel.sv
// Directed scoreboard bench for rr_mux_sel: stimulus pushes expected outputs, a monitor pops and compares.
module tb_rr_mux_sel;

    localparam int WIDTH    = 8;
    localparam int CH       = 4;
    localparam int MAX_HOLD = 4;

    logic                clk = 1'b0;
    logic                rstN;
    logic [CH-1:0]       req;
    logic [CH*WIDTH-1:0] data_in;
    logic [CH-1:0]       grant;
    logic [1:0]          sel;
    logic [WIDTH-1:0]    out;
    logic                valid;

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic [1:0] sel;
        logic [7:0] out;
        logic       valid;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   total = 0;
    int   bad   = 0;

    rr_mux_sel #(.WIDTH(WIDTH), .CH(CH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rstN    (rstN),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .sel     (sel),
        .out     (out),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic compareField(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField({e.name, ".grant"}, 32'(grant), 32'(e.grant));
        compareField({e.name, ".sel"},   32'(sel),   32'(e.sel));
        compareField({e.name, ".out"},   32'(out),   32'(e.out));
        compareField({e.name, ".valid"}, 32'(valid), 32'(e.valid));
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            compareField("inv.valid", 32'(valid), 32'(grant != 4'b0000));
            compareField("inv.onehot", 32'($onehot0(grant)), 32'(1));
            if (valid === 1'b1) begin
                compareField("inv.selmatch", 32'(grant), 32'(4'b0001 << sel));
            end
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput(monExp);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g,
                                 input logic [1:0] s, input logic [7:0] o, input logic v, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        req     = r;
        data_in = d;
        e.name  = nm;
        e.grant = g;
        e.sel   = s;
        e.out   = o;
        e.valid = v;
        expQ.push_back(e);
    endtask

    task automatic pulseReset(input string nm);
        exp_t z;
        z.name  = nm;
        z.grant = 4'b0000;
        z.sel   = 2'd0;
        z.out   = 8'h00;
        z.valid = 1'b0;
        @(negedge clk);
        #2;
        rstN = 1'b0;
        req  = 4'b0000;
        #1;
        checkOutput(z);
        @(posedge clk);
        @(negedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t por;
        int   owner;
        por.name  = "por";
        por.grant = 4'b0000;
        por.sel   = 2'd0;
        por.out   = 8'h00;
        por.valid = 1'b0;

        rstN    = 1'b0;
        req     = 4'b0000;
        data_in = '0;
        #3;
        checkOutput(por);
        @(negedge clk);
        #1;
        rstN = 1'b1;

        applyStimulus(4'b1010, {8'h31, 8'h21, 8'h12, 8'h01}, 4'b0010, 2'd1, 8'h12, 1'b1, "ptr0_pick1");
        applyStimulus(4'b1000, {8'h34, 8'h21, 8'h12, 8'h01}, 4'b1000, 2'd3, 8'h34, 1'b1, "handover3");
        applyStimulus(4'b0000, {8'h44, 8'h44, 8'h44, 8'h44}, 4'b0000, 2'd0, 8'h34, 1'b0, "release");
        applyStimulus(4'b0011, {8'h33, 8'h22, 8'h1F, 8'h0F}, 4'b0001, 2'd0, 8'h0F, 1'b1, "wrap_pick0");
        applyStimulus(4'b0011, {8'h33, 8'h22, 8'h1F, 8'hF0}, 4'b0001, 2'd0, 8'hF0, 1'b1, "hold_newdata");
        applyStimulus(4'b0111, {8'h33, 8'h2E, 8'h1F, 8'hE0}, 4'b0001, 2'd0, 8'hE0, 1'b1, "others_wait");
        applyStimulus(4'b0000, {8'h33, 8'h2E, 8'h1F, 8'hD0}, 4'b0000, 2'd0, 8'hE0, 1'b0, "drop_keep_out");
        applyStimulus(4'b0000, {8'h55, 8'h55, 8'h55, 8'h55}, 4'b0000, 2'd0, 8'hE0, 1'b0, "idle_stays");
        applyStimulus(4'b1011, {8'h33, 8'h22, 8'hB1, 8'h01}, 4'b0010, 2'd1, 8'hB1, 1'b1, "ptr1_pick1");
        applyStimulus(4'b1001, {8'hC3, 8'h22, 8'hB1, 8'h01}, 4'b1000, 2'd3, 8'hC3, 1'b1, "rot_to3");
        applyStimulus(4'b0001, {8'hC3, 8'h22, 8'hB1, 8'h0C}, 4'b0001, 2'd0, 8'h0C, 1'b1, "rot_wrap0");

        for (int t = 1; t <= 12; t++) begin
`ifdef RR_MUX_SEL_TIMEOUT_EN
            owner = (t / MAX_HOLD) % 2;
`else
            owner = 0;
`endif
            applyStimulus(4'b0011, {8'h33, 8'h22, 8'hA1, 8'hA0},
                          (owner == 1) ? 4'b0010 : 4'b0001, 2'(owner),
                          (owner == 1) ? 8'hA1 : 8'hA0, 1'b1, $sformatf("hold%0d", t));
        end

        applyStimulus(4'b0100, {8'h33, 8'h5C, 8'hA1, 8'hA0}, 4'b0100, 2'd2, 8'h5C, 1'b1, "pre_reset");
        pulseReset("async_rst");
        applyStimulus(4'b1001, {8'hD3, 8'h22, 8'h11, 8'h99}, 4'b0001, 2'd0, 8'h99, 1'b1, "post_rst_ch0");
        pulseReset("async_rst2");
        applyStimulus(4'b0100, {8'h33, 8'hA5, 8'h22, 8'h11}, 4'b0100, 2'd2, 8'hA5, 1'b1, "first_ch2");
        applyStimulus(4'b0100, {8'h33, 8'hB6, 8'h22, 8'h11}, 4'b0100, 2'd2, 8'hB6, 1'b1, "hold_ch2");
        applyStimulus(4'b0000, {8'h77, 8'h77, 8'h77, 8'h77}, 4'b0000, 2'd0, 8'hB6, 1'b0, "final_idle");

        @(negedge clk);
        @(negedge clk);
        #1;
        compareField("queue_drained", 32'(expQ.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_sel.md
RR_MUX_SEL -- requirements
Module: rr_mux_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL have parameter CH, default 4, number of input channels (>=2).
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles per channel when the timeout feature is compiled in (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, CH, per-channel request; bit i requests channel i.
REQ-007 SHALL have port data_in, input, CH*WIDTH, channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port grant, output, CH, registered one-hot grant; all-zero when idle.
REQ-009 SHALL have port sel, output, $clog2(CH), registered binary index of the granted channel.
REQ-010 SHALL have port out, output, WIDTH, registered data of the granted channel.
REQ-011 SHALL have port valid, output, 1, high exactly when grant is non-zero.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one channel owns out).
REQ-013 SHALL keep a rotating priority pointer ptr, range 0..CH-1; the search for a new owner starts at ptr and wraps from CH-1 to 0.
REQ-014 IDLE: on an edge where req is non-zero, SHALL grant the first requester at or after ptr, enter GRANT, and set valid=1; latency is one cycle from req sampled to grant visible.
REQ-015 IDLE with req all-zero SHALL remain in IDLE with grant=0, valid=0, out unchanged.
REQ-016 GRANT: on every edge where req[sel]=1 (and no forced rotation), SHALL keep grant/sel and load out with data_in of channel sel sampled on that edge.
REQ-017 GRANT: on an edge where req[sel]=0 and another req bit is set, SHALL move grant directly to the next requester after sel (no idle bubble) and load out from that channel on the same edge.
REQ-018 GRANT: on an edge where req is all-zero, SHALL enter IDLE, clear grant and valid, and hold out at its last value.
REQ-019 Every grant change SHALL set ptr to (new or released owner index + 1) mod CH, so a releasing channel has lowest priority next search.
REQ-020 grant, sel and valid SHALL always be mutually consistent on the same cycle; grant SHALL never have more than one bit set.
REQ-021 Simultaneous requests on the IDLE->GRANT edge SHALL be resolved solely by ptr order; requests arriving while another channel holds grant SHALL wait.

Reset
REQ-022 rstN low SHALL immediately, without a clock edge, force state=IDLE, ptr=0, grant=0, sel=0, out=0, valid=0, hold counter=0.
REQ-023 Reset asserted mid-grant SHALL abort the grant; after rstN rises, arbitration restarts from channel 0 on the first edge with req non-zero.

Configuration
REQ-024 Macro RR_MUX_SEL_TIMEOUT_EN defined SHALL add a hold counter that increments each GRANT cycle and resets to 0 on every grant change.
REQ-025 With RR_MUX_SEL_TIMEOUT_EN, when the counter reaches MAX_HOLD-1 and any other req bit is set, the next edge SHALL force rotation per REQ-017 even though req[sel]=1; with no other requester, grant SHALL be kept and the counter SHALL restart at 0.
REQ-026 Without RR_MUX_SEL_TIMEOUT_EN, no counter SHALL exist, MAX_HOLD SHALL be ignored, and a channel SHALL hold grant for as long as its req stays high.

Verification
REQ-027 Reset, then req=4'b0100, data ch2=8'hA5 -> next edge grant=4'b0100, sel=2, valid=1, out=8'hA5.
REQ-028 From IDLE with ptr=0, req=4'b1010 -> grant=4'b0010; drop req[1] -> next edge grant=4'b1000 without a valid gap; ptr becomes 0 (wrap).
REQ-029 Channel 0 holds, all req drop -> next edge valid=0, grant=0, out keeps last data value.
REQ-030 With RR_MUX_SEL_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held constant -> grant alternates 0001/0010 every 4 cycles; without the macro grant stays 4'b0001 indefinitely.
REQ-031 Assert rstN low between edges during GRANT -> all outputs 0 immediately; release with req=4'b1001 -> grant=4'b0001.
REQ-032 Random req/data over 10000 cycles, CH=3, WIDTH=5 -> grant always one-hot or zero, out always equals the granted channel's data from the previous edge, no requester starved beyond (CH-1) grant periods.
